// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - CPU-word to multi-beat asynchronous SRAM burst controller
module sram_burst_ctrl #(
  parameter int DW_SRAM = 16,
  parameter int ADDR_W  = 18,
  parameter int WORDS   = 2,
  parameter int WAIT    = 1,
  parameter int BASE    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [31:0]                address,
  input  logic [DW_SRAM*WORDS-1:0]   wdata,
  output logic [DW_SRAM*WORDS-1:0]   rdata,
  output logic                       ready,
  output logic                       SRAM_WE_N,
  inout  wire  [DW_SRAM-1:0]         SRAM_DQ,
  output logic [ADDR_W-1:0]          SRAM_ADDR
);

  localparam int CW = DW_SRAM * WORDS;
  localparam int SH = $clog2(CW / 8);
  localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [BW-1:0]   beat;
  logic [3:0]      wait_cnt;
  logic            is_wr;
  logic [CW-1:0]   wdata_q;
  logic [CW-1:0]   rd_buf;
  logic [CW-1:0]   rd_next;
  logic            req;
  logic            beat_end;
  logic            last_beat;

  assign req       = wr_en | rd_en;
  assign beat_end  = (wait_cnt == 4'(WAIT));
  assign last_beat = (beat == BW'(WORDS - 1));

  // The bus is only driven while a write beat is active (write enable low).
  assign SRAM_DQ = SRAM_WE_N ? {DW_SRAM{1'bz}} : wdata_q[beat*DW_SRAM +: DW_SRAM];

  // Stall the CPU from the moment a request is seen until the DONE cycle.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~req;
      ACCESS:  ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Read assembly: merge the sampled beat into a shadow buffer so rdata only changes on completion.
  always_comb begin
    rd_next = rd_buf;
    rd_next[beat*DW_SRAM +: DW_SRAM] = SRAM_DQ;
  end

  // Access sequencer: latch request, walk beats with per-beat wait states, publish read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      wait_cnt  <= '0;
      is_wr     <= 1'b0;
      wdata_q   <= '0;
      rd_buf    <= '0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= ACCESS;
            is_wr     <= wr_en;
            wdata_q   <= wdata;
            beat      <= '0;
            wait_cnt  <= '0;
            // Word index scaled by beats per word; low byte-lane bits fall out of the shift.
            SRAM_ADDR <= ADDR_W'(((address - 32'(BASE)) >> SH) * 32'(WORDS));
            SRAM_WE_N <= ~wr_en;
          end
        end
        ACCESS: begin
          if (beat_end) begin
            wait_cnt <= '0;
            if (!is_wr) rd_buf <= rd_next;
            if (last_beat) begin
              state     <= DONE;
              beat      <= '0;
              SRAM_WE_N <= 1'b1;
              if (!is_wr) rdata <= rd_next;
            end else begin
              beat      <= beat + BW'(1);
              SRAM_ADDR <= SRAM_ADDR + ADDR_W'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - scoreboard bench for sram_burst_ctrl (default and 8-bit/4-beat instances)
module tb_sram_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults (16-bit SRAM, 2 beats, 1 wait)
  logic        wr_en_a = 1'b0, rd_en_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic [31:0] rdata_a;
  logic        ready_a, we_n_a;
  wire  [15:0] dq_a;
  logic [17:0] sa_a;
  logic [15:0] mem_a [0:262143];

  // Instance B: 8-bit SRAM, 4 beats, no wait
  logic        wr_en_b = 1'b0, rd_en_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic [31:0] rdata_b;
  logic        ready_b, we_n_b;
  wire  [7:0]  dq_b;
  logic [17:0] sa_b;
  logic [7:0]  mem_b [0:262143];

  sram_burst_ctrl dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .rd_en(rd_en_a), .address(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .SRAM_WE_N(we_n_a),
    .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a)
  );

  sram_burst_ctrl #(.DW_SRAM(8), .ADDR_W(18), .WORDS(4), .WAIT(0), .BASE(1024)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b), .address(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .SRAM_WE_N(we_n_b),
    .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b)
  );

  // SRAM models: drive the bus whenever write enable is high, store on write cycles
  assign dq_a = we_n_a ? mem_a[sa_a] : 16'bz;
  assign dq_b = we_n_b ? mem_b[sa_b] : 8'bz;
  always @(posedge clk) if (!we_n_a) mem_a[sa_a] <= dq_a;
  always @(posedge clk) if (!we_n_b) mem_b[sa_b] <= dq_b;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct packed { logic [31:0] low;  logic [31:0] rd;   } acc_t;

  beat_t beat_qa[$], beat_qb[$];
  acc_t  acc_qa[$],  acc_qb[$];
  beat_t be_a, be_b;
  acc_t  ae_a, ae_b;
  int    cnt_a = 0, cnt_b = 0;
  int    vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Monitor A: every write cycle and every completed access is matched against the queues
  always @(negedge clk) begin
    if (!we_n_a) begin
      if (beat_qa.size() == 0) fail_now("a_unexpected_write_cycle");
      else begin
        be_a = beat_qa.pop_front();
        chk("a_wr_addr", 32'(sa_a), be_a.addr);
        chk("a_wr_data", 32'(dq_a), be_a.data);
      end
    end
    if (!ready_a) cnt_a++;
    else if (cnt_a != 0) begin
      if (acc_qa.size() == 0) fail_now("a_unexpected_access");
      else begin
        ae_a = acc_qa.pop_front();
        chk("a_ready_low_cycles", 32'(cnt_a), ae_a.low);
        chk("a_rdata", rdata_a, ae_a.rd);
      end
      cnt_a = 0;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!we_n_b) begin
      if (beat_qb.size() == 0) fail_now("b_unexpected_write_cycle");
      else begin
        be_b = beat_qb.pop_front();
        chk("b_wr_addr", 32'(sa_b), be_b.addr);
        chk("b_wr_data", 32'(dq_b), be_b.data);
      end
    end
    if (!ready_b) cnt_b++;
    else if (cnt_b != 0) begin
      if (acc_qb.size() == 0) fail_now("b_unexpected_access");
      else begin
        ae_b = acc_qb.pop_front();
        chk("b_ready_low_cycles", 32'(cnt_b), ae_b.low);
        chk("b_rdata", rdata_b, ae_b.rd);
      end
      cnt_b = 0;
    end
  end

  // Expected write cycles on A: 2 beats x 2 cycles, low half first
  task automatic exp_wr_a(input logic [31:0] waddr, input logic [31:0] d);
    beat_qa.push_back('{waddr,     {16'h0, d[15:0]}});
    beat_qa.push_back('{waddr,     {16'h0, d[15:0]}});
    beat_qa.push_back('{waddr + 1, {16'h0, d[31:16]}});
    beat_qa.push_back('{waddr + 1, {16'h0, d[31:16]}});
  endtask

  task automatic run_a(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    bit done;
    @(posedge clk); #1;
    wr_en_a = w; rd_en_a = r; addr_a = a; wdata_a = d;
    @(posedge clk); #1;
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready_a) begin done = 1'b1; break; end
    end
    if (!done) fail_now("a_access_timeout");
  endtask

  task automatic run_b(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    bit done;
    @(posedge clk); #1;
    wr_en_b = w; rd_en_b = r; addr_b = a; wdata_b = d;
    @(posedge clk); #1;
    wr_en_b = 1'b0; rd_en_b = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready_b) begin done = 1'b1; break; end
    end
    if (!done) fail_now("b_access_timeout");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_we_n", 32'(we_n_a), 32'd1);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_sram_addr", 32'(sa_a), 32'h0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    rd_en_a = 1'b1;
    #1 chk("rst_ready_with_req", 32'(ready_a), 32'd0);
    rd_en_a = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Basic write/read at BASE
    exp_wr_a(32'd0, 32'hDEADBEEF); acc_qa.push_back('{32'd5, 32'h0});
    run_a(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    acc_qa.push_back('{32'd5, 32'hDEADBEEF});
    run_a(1'b0, 1'b1, 32'd1024, 32'h0);

    // 1028 and 1030 share CPU word 1 -> SRAM 2/3; writes leave rdata alone
    exp_wr_a(32'd2, 32'h12345678); acc_qa.push_back('{32'd5, 32'hDEADBEEF});
    run_a(1'b1, 1'b0, 32'd1028, 32'h12345678);
    exp_wr_a(32'd2, 32'hCAFEF00D); acc_qa.push_back('{32'd5, 32'hDEADBEEF});
    run_a(1'b1, 1'b0, 32'd1030, 32'hCAFEF00D);
    acc_qa.push_back('{32'd5, 32'hCAFEF00D});
    run_a(1'b0, 1'b1, 32'd1028, 32'h0);
    acc_qa.push_back('{32'd5, 32'hCAFEF00D});
    run_a(1'b0, 1'b1, 32'd1031, 32'h0);

    // Simultaneous write and read: write wins, rdata unchanged
    exp_wr_a(32'd4, 32'h0000FFFF); acc_qa.push_back('{32'd5, 32'hCAFEF00D});
    run_a(1'b1, 1'b1, 32'd1032, 32'h0000FFFF);
    acc_qa.push_back('{32'd5, 32'h0000FFFF});
    run_a(1'b0, 1'b1, 32'd1032, 32'h0);

    // Address 0 is below BASE: (0-1024)>>2 = 0x3FFFFF00, x2 = 0x7FFFFE00, 18 bits = 0x3FE00
    exp_wr_a(32'h3FE00, 32'hA5A55A5A); acc_qa.push_back('{32'd5, 32'h0000FFFF});
    run_a(1'b1, 1'b0, 32'd0, 32'hA5A55A5A);
    acc_qa.push_back('{32'd5, 32'hA5A55A5A});
    run_a(1'b0, 1'b1, 32'd0, 32'h0);

    // Reset during first cycle of beat 1 of a write: only beat 0 reaches the SRAM
    beat_qa.push_back('{32'd0, 32'h2222});
    beat_qa.push_back('{32'd0, 32'h2222});
    acc_qa.push_back('{32'd3, 32'h0});
    @(posedge clk); #1;
    wr_en_a = 1'b1; addr_a = 32'd1024; wdata_a = 32'h11112222;
    @(posedge clk); #1;
    wr_en_a = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(we_n_a), 32'd1);
    chk("abort_rdata", rdata_a, 32'h0);
    chk("abort_ready", 32'(ready_a), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    acc_qa.push_back('{32'd5, 32'hDEAD2222});
    run_a(1'b0, 1'b1, 32'd1024, 32'h0);

    // Instance B: 4 byte beats, one cycle each
    beat_qb.push_back('{32'd0, 32'h78});
    beat_qb.push_back('{32'd1, 32'h56});
    beat_qb.push_back('{32'd2, 32'h34});
    beat_qb.push_back('{32'd3, 32'h12});
    acc_qb.push_back('{32'd5, 32'h0});
    run_b(1'b1, 1'b0, 32'd1024, 32'h12345678);
    acc_qb.push_back('{32'd5, 32'h12345678});
    run_b(1'b0, 1'b1, 32'd1024, 32'h0);

    repeat (3) @(negedge clk);
    chk("a_beats_left", 32'(beat_qa.size()), 32'd0);
    chk("a_accesses_left", 32'(acc_qa.size()), 32'd0);
    chk("b_beats_left", 32'(beat_qb.size()), 32'd0);
    chk("b_accesses_left", 32'(acc_qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
